// File: rtl/fetch_sequencer.sv
// PC-redirect arbiter in front of instruction fetch: orders EX branches, ID jumps,
// halt/resume and load-use stalls into registered fetch-control outputs.
module fetch_sequencer #(
  parameter int unsigned PC_W         = 8,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clkwire,
  input  logic            rstwire,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp_req,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            stall_req,
  input  logic            halt_req,
  input  logic            resume,
  input  logic [PC_W-1:0] npc,
  output logic            jump_selector,
  output logic [PC_W-1:0] jump_address,
  output logic            fetch_en,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic [1:0]      seq_state,
  output logic [7:0]      redirect_cnt,
  output logic [15:0]     stall_cnt
);

  localparam int unsigned FC_W = 2;
  localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic              js_nx, fe_nx, fi_nx, fx_nx;
  logic [PC_W-1:0]   ja_nx, halt_pc, hpc_nx;
  logic [FC_W-1:0]   fcnt, fcnt_nx;

  assign seq_state = state;

  // Next-state and next-output decode; EX branch outranks everything in every state.
  always_comb begin
    state_nx = state;
    js_nx    = 1'b0;
    ja_nx    = jump_address;
    fe_nx    = 1'b1;
    fi_nx    = 1'b0;
    fx_nx    = 1'b0;
    hpc_nx   = halt_pc;
    fcnt_nx  = fcnt;
    if (br_taken) begin
      js_nx    = 1'b1;
      ja_nx    = br_target;
      fi_nx    = 1'b1;
      fx_nx    = 1'b1;
      fcnt_nx  = FLUSH_LOAD;
      state_nx = (FLUSH_LOAD == '0) ? RUN : FLUSH;
    end else begin
      case (state)
        RUN: begin
          if (jmp_req) begin
            js_nx = 1'b1;
            ja_nx = jmp_target;
            fi_nx = 1'b1;
          end else if (halt_req) begin
            hpc_nx   = npc;
            fe_nx    = 1'b0;
            fi_nx    = 1'b1;
            state_nx = HALT;
          end else if (stall_req) begin
            fe_nx    = 1'b0;
            state_nx = STALL;
          end
        end
        STALL: begin
          if (stall_req) fe_nx = 1'b0;
          else           state_nx = RUN;
        end
        FLUSH: begin
          // Wrong-path jmp/halt/stall requests are dropped while squashing.
          if (fcnt == '0) begin
            state_nx = RUN;
          end else begin
            fcnt_nx = fcnt - FC_W'(1);
            fi_nx   = 1'b1;
          end
        end
        HALT: begin
          if (resume) begin
            js_nx    = 1'b1;
            ja_nx    = halt_pc;
            state_nx = RUN;
          end else begin
            fe_nx = 1'b0;
          end
        end
      endcase
    end
  end

  // State register, registered outputs and saturating event counters.
  always_ff @(posedge clkwire or posedge rstwire) begin
    if (rstwire) begin
      state         <= RUN;
      jump_selector <= 1'b0;
      jump_address  <= '0;
      fetch_en      <= 1'b0;
      flush_ifid    <= 1'b0;
      flush_idex    <= 1'b0;
      halt_pc       <= '0;
      fcnt          <= '0;
      redirect_cnt  <= '0;
      stall_cnt     <= '0;
    end else begin
      state         <= state_nx;
      jump_selector <= js_nx;
      jump_address  <= ja_nx;
      fetch_en      <= fe_nx;
      flush_ifid    <= fi_nx;
      flush_idex    <= fx_nx;
      halt_pc       <= hpc_nx;
      fcnt          <= fcnt_nx;
      if (js_nx && (redirect_cnt != 8'hFF))
        redirect_cnt <= redirect_cnt + 8'd1;
      if (!fe_nx && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic against a
// cycle-level behavioural model of the redirect/stall/halt rules.
module tb_fetch_sequencer;

  localparam int unsigned PC_W = 8;
  localparam int FC = 2;
  localparam int M_RUN = 0, M_STALL = 1, M_FLUSH = 2, M_HALT = 3;

  logic            clkwire, rstwire;
  logic            br_taken, jmp_req, stall_req, halt_req, resume;
  logic [PC_W-1:0] br_target, jmp_target, npc;
  logic            jump_selector, fetch_en, flush_ifid, flush_idex;
  logic [PC_W-1:0] jump_address;
  logic [1:0]      seq_state;
  logic [7:0]      redirect_cnt;
  logic [15:0]     stall_cnt;

  int errors = 0;
  int checks = 0;

  // Model: mode, extra flush cycles still owed, remembered halt PC, expected outputs.
  int       m_mode, m_left, m_rc, m_sc;
  logic [7:0] m_hpc, m_ja;
  logic     m_js, m_fe, m_fi, m_fx;

  fetch_sequencer #(.PC_W(PC_W), .FLUSH_CYCLES(FC)) dut (
    .clkwire(clkwire), .rstwire(rstwire),
    .br_taken(br_taken), .br_target(br_target),
    .jmp_req(jmp_req), .jmp_target(jmp_target),
    .stall_req(stall_req), .halt_req(halt_req), .resume(resume), .npc(npc),
    .jump_selector(jump_selector), .jump_address(jump_address),
    .fetch_en(fetch_en), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .seq_state(seq_state), .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
  );

  initial clkwire = 1'b0;
  always #5 clkwire = ~clkwire;

  function automatic logic [37:0] obs_vec();
    return {jump_selector, jump_address, fetch_en, flush_ifid, flush_idex,
            seq_state, redirect_cnt, stall_cnt};
  endfunction

  function automatic logic [37:0] exp_vec();
    return {m_js, m_ja, m_fe, m_fi, m_fx, 2'(m_mode), 8'(m_rc), 16'(m_sc)};
  endfunction

  function automatic void model_reset();
    m_mode = M_RUN; m_left = 0; m_rc = 0; m_sc = 0;
    m_hpc = '0; m_ja = '0;
    m_js = 1'b0; m_fe = 1'b0; m_fi = 1'b0; m_fx = 1'b0;
  endfunction

  function automatic void model_step();
    m_js = 1'b0; m_fi = 1'b0; m_fx = 1'b0; m_fe = 1'b1;
    if (br_taken) begin
      m_js = 1'b1; m_ja = br_target; m_fi = 1'b1; m_fx = 1'b1;
      m_left = FC - 1;
      m_mode = (m_left > 0) ? M_FLUSH : M_RUN;
    end else if (m_mode == M_RUN) begin
      if (jmp_req) begin
        m_js = 1'b1; m_ja = jmp_target; m_fi = 1'b1;
      end else if (halt_req) begin
        m_hpc = npc; m_fe = 1'b0; m_fi = 1'b1; m_mode = M_HALT;
      end else if (stall_req) begin
        m_fe = 1'b0; m_mode = M_STALL;
      end
    end else if (m_mode == M_STALL) begin
      if (stall_req) m_fe = 1'b0;
      else m_mode = M_RUN;
    end else if (m_mode == M_FLUSH) begin
      if (m_left == 0) m_mode = M_RUN;
      else begin m_left = m_left - 1; m_fi = 1'b1; end
    end else begin
      if (resume) begin m_js = 1'b1; m_ja = m_hpc; m_mode = M_RUN; end
      else m_fe = 1'b0;
    end
    if (m_js && m_rc < 255) m_rc = m_rc + 1;
    if (!m_fe && m_sc < 65535) m_sc = m_sc + 1;
  endfunction

  // Drive one cycle of inputs, clock it in, advance the model, settle past the edge.
  task automatic step(input logic bt, input logic [7:0] bta, input logic jr,
                      input logic [7:0] jta, input logic sr, input logic hr,
                      input logic rs, input logic [7:0] np);
    br_taken = bt; br_target = bta; jmp_req = jr; jmp_target = jta;
    stall_req = sr; halt_req = hr; resume = rs; npc = np;
    @(posedge clkwire);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rstwire = 1'b1;
    step(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00);
    model_reset();
    repeat (2) @(posedge clkwire);
    #1;
    checks++;
    if (obs_vec() !== 38'd0) begin
      errors++; $display("FAIL reset_values: got %h want 0", obs_vec());
    end
    rstwire = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'(i));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL idle: got %h want %h", obs_vec(), exp_vec());
      end
      checks++;
      if (fetch_en !== 1'b1 || jump_selector !== 1'b0 || seq_state !== 2'd0 ||
          redirect_cnt !== 8'd0 || stall_cnt !== 16'd0) begin
        errors++;
        $display("FAIL idle_fixed: fe=%b js=%b st=%0d rc=%0d sc=%0d want 1 0 0 0 0",
                 fetch_en, jump_selector, seq_state, redirect_cnt, stall_cnt);
      end
    end
  endtask

  task automatic test_branch();
    int fi_cycles;
    logic [7:0] rc0;
    rc0 = redirect_cnt;
    step(1, 8'h20, 0, 8'h00, 0, 0, 0, 8'h11);
    checks++;
    if (jump_selector !== 1'b1 || jump_address !== 8'h20 || flush_ifid !== 1'b1 ||
        flush_idex !== 1'b1 || seq_state !== 2'd2) begin
      errors++;
      $display("FAIL branch_redirect: js=%b addr=%h fi=%b fx=%b st=%0d want 1 20 1 1 2",
               jump_selector, jump_address, flush_ifid, flush_idex, seq_state);
    end
    fi_cycles = 1;
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h12);
      if (flush_ifid === 1'b1) fi_cycles++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL branch_seq: got %h want %h", obs_vec(), exp_vec());
      end
    end
    checks++;
    if (fi_cycles != 2 || seq_state !== 2'd0 || redirect_cnt !== rc0 + 8'd1) begin
      errors++;
      $display("FAIL branch_flush_len: fi_cycles=%0d st=%0d rc=%0d want 2 0 %0d",
               fi_cycles, seq_state, redirect_cnt, rc0 + 8'd1);
    end
  endtask

  task automatic test_branch_vs_jump();
    step(1, 8'h40, 1, 8'h10, 0, 0, 0, 8'h21);
    checks++;
    if (jump_address !== 8'h40 || flush_idex !== 1'b1 || jump_selector !== 1'b1) begin
      errors++;
      $display("FAIL br_over_jmp: addr=%h fx=%b js=%b want 40 1 1",
               jump_address, flush_idex, jump_selector);
    end
    step(0, 8'h00, 1, 8'h77, 1, 0, 0, 8'h22);
    checks++;
    if (jump_selector !== 1'b0 || jump_address !== 8'h40 || fetch_en !== 1'b1 ||
        flush_idex !== 1'b0 || seq_state !== 2'd2) begin
      errors++;
      $display("FAIL flush_ignores: js=%b addr=%h fe=%b fx=%b st=%0d want 0 40 1 0 2",
               jump_selector, jump_address, fetch_en, flush_idex, seq_state);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h23);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL br_jmp_tail: got %h want %h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_stall_branch();
    logic [15:0] sc0;
    sc0 = stall_cnt;
    step(0, 8'h00, 0, 8'h00, 1, 0, 0, 8'h30);
    checks++;
    if (fetch_en !== 1'b0 || seq_state !== 2'd1) begin
      errors++; $display("FAIL stall_enter: fe=%b st=%0d want 0 1", fetch_en, seq_state);
    end
    step(1, 8'h05, 0, 8'h00, 1, 0, 0, 8'h30);
    checks++;
    if (jump_selector !== 1'b1 || jump_address !== 8'h05 || seq_state !== 2'd2 ||
        fetch_en !== 1'b1) begin
      errors++;
      $display("FAIL stall_branch: js=%b addr=%h st=%0d fe=%b want 1 05 2 1",
               jump_selector, jump_address, seq_state, fetch_en);
    end
    step(0, 8'h00, 0, 8'h00, 1, 0, 0, 8'h30);
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h31);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL stall_tail: got %h want %h", obs_vec(), exp_vec());
      end
    end
    checks++;
    if (stall_cnt !== sc0 + 16'd1) begin
      errors++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, sc0 + 16'd1);
    end
  endtask

  task automatic test_halt_resume(input logic [7:0] hpc);
    step(0, 8'h00, 0, 8'h00, 0, 1, 0, hpc);
    checks++;
    if (fetch_en !== 1'b0 || flush_ifid !== 1'b1 || seq_state !== 2'd3) begin
      errors++;
      $display("FAIL halt_enter: fe=%b fi=%b st=%0d want 0 1 3", fetch_en, flush_ifid, seq_state);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'($urandom));
      checks++;
      if (fetch_en !== 1'b0 || flush_ifid !== 1'b0 || seq_state !== 2'd3) begin
        errors++;
        $display("FAIL halt_hold: fe=%b fi=%b st=%0d want 0 0 3", fetch_en, flush_ifid, seq_state);
      end
    end
    step(0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h00);
    checks++;
    if (jump_selector !== 1'b1 || jump_address !== hpc || fetch_en !== 1'b1 ||
        seq_state !== 2'd0) begin
      errors++;
      $display("FAIL resume: js=%b addr=%h fe=%b st=%0d want 1 %h 1 0",
               jump_selector, jump_address, fetch_en, seq_state, hpc);
    end
    step(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL halt_tail: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_resume_vs_branch();
    step(0, 8'h00, 0, 8'h00, 0, 1, 0, 8'h55);
    step(1, 8'h9A, 0, 8'h00, 0, 0, 1, 8'h00);
    checks++;
    if (jump_address !== 8'h9A || seq_state !== 2'd2 || flush_idex !== 1'b1) begin
      errors++;
      $display("FAIL resume_vs_branch: addr=%h st=%0d fx=%b want 9a 2 1",
               jump_address, seq_state, flush_idex);
    end
    repeat (3) step(0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h00);
    checks++;
    if (obs_vec() !== exp_vec() || jump_address !== 8'h9A) begin
      errors++; $display("FAIL halt_cancelled: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    step(1, 8'h60, 0, 8'h00, 0, 0, 0, 8'h00);
    #2 rstwire = 1'b1;
    #1 model_reset();
    checks++;
    if (obs_vec() !== 38'd0) begin
      errors++; $display("FAIL rst_mid_flush: got %h want 0", obs_vec());
    end
    @(posedge clkwire); #1 rstwire = 1'b0;
    step(0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h00);
    checks++;
    if (jump_selector !== 1'b0 || seq_state !== 2'd0 || fetch_en !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_flush: js=%b st=%0d fe=%b want 0 0 1", jump_selector, seq_state, fetch_en);
    end
    step(0, 8'h00, 0, 8'h00, 0, 1, 0, 8'h44);
    step(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00);
    #2 rstwire = 1'b1;
    #1 model_reset();
    checks++;
    if (obs_vec() !== 38'd0) begin
      errors++; $display("FAIL rst_mid_halt: got %h want 0", obs_vec());
    end
    @(posedge clkwire); #1 rstwire = 1'b0;
    step(0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h00);
    checks++;
    if (jump_selector !== 1'b0 || jump_address !== 8'h00 || seq_state !== 2'd0 ||
        redirect_cnt !== 8'd0) begin
      errors++;
      $display("FAIL post_rst_halt: js=%b addr=%h st=%0d rc=%0d want 0 00 0 0",
               jump_selector, jump_address, seq_state, redirect_cnt);
    end
  endtask

  task automatic test_redirect_sat();
    for (int i = 0; i < 260; i++) begin
      step(0, 8'h00, 1, 8'(i * 3), 0, 0, 0, 8'h00);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL jmp_stream: got %h want %h", obs_vec(), exp_vec());
      end
    end
    checks++;
    if (redirect_cnt !== 8'd255 || jump_selector !== 1'b1) begin
      errors++; $display("FAIL redirect_sat: rc=%0d js=%b want 255 1", redirect_cnt, jump_selector);
    end
  endtask

  task automatic test_random();
    logic sr;
    sr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) sr = ~sr;
      step(logic'($urandom_range(0, 9) == 0), 8'($urandom),
           logic'($urandom_range(0, 6) == 0), 8'($urandom), sr,
           logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 4) == 0),
           8'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 rstwire = 1'b1;
        #1 model_reset();
        checks++;
        if (obs_vec() !== 38'd0) begin
          errors++; $display("FAIL random_rst[%0d]: got %h want 0", i, obs_vec());
        end
        @(posedge clkwire); #1 rstwire = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_branch_vs_jump();
    test_stall_branch();
    test_halt_resume(8'h33);
    test_halt_resume(8'hFF);
    test_resume_vs_branch();
    test_reset_mid();
    test_redirect_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
